// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper drive: FSM state encoding, direction
// constants and the full-step coil phase table.
package stepper_pkg;

    typedef enum logic [1:0] {
        sIDLE  = 2'b00,
        sACCEL = 2'b01,
        sRUN   = 2'b10,
        sDECEL = 2'b11
    } state_e;

    localparam logic FW = 1'b1;
    localparam logic BW = 1'b0;

    // Coil pattern {B_n, A_n, B, A} for phase index 0..3.
    function automatic logic [3:0] phase_lut(input logic [1:0] idx);
        logic [3:0] pat;
        unique case (idx)
            2'd0:    pat = 4'b0011;
            2'd1:    pat = 4'b0110;
            2'd2:    pat = 4'b1100;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/stepper_drive_if.sv
// Command/status bundle between the direction/enable controller (master)
// and the stepper drive (slave).
//   dir   : requested direction, FW=1 / BW=0
//   en    : motion request, level-sensitive
//   step  : one-cycle pulse per step taken
//   phase : coil drive {B_n, A_n, B, A}
//   pos   : signed position count
//   busy  : drive not idle
interface stepper_drive_if #(
    parameter int unsigned POS_W = 16
);
    logic             dir;
    logic             en;
    logic             step;
    logic [3:0]       phase;
    logic [POS_W-1:0] pos;
    logic             busy;

    modport master (output dir, en, input step, phase, pos, busy);
    modport slave  (input dir, en, output step, phase, pos, busy);
endinterface

// File: rtl/stepper_phase_seq.sv
// Phase index and position tracking. Each taken step advances the phase
// index (mod 4) and the position counter (mod 2^POS_W) in the latched
// direction.
//   clk_i, rst_ni : clock, async active-low reset
//   step_take_i   : a step is taken on this edge
//   dir_l_i       : latched direction for the current move
//   phase_o       : unmasked coil pattern for the current index
//   pos_o         : position count
module stepper_phase_seq
    import stepper_pkg::*;
#(
    parameter int unsigned POS_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_take_i,
    input  logic             dir_l_i,
    output logic [3:0]       phase_o,
    output logic [POS_W-1:0] pos_o
);

    logic [1:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        idx_d = idx_q;
        pos_d = pos_q;
        if (step_take_i) begin
            if (dir_l_i == FW) begin
                idx_d = idx_q + 2'd1;
                pos_d = pos_q + POS_W'(1);
            end else begin
                idx_d = idx_q - 2'd1;
                pos_d = pos_q - POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= 2'd0;
            pos_q <= '0;
        end else begin
            idx_q <= idx_d;
            pos_q <= pos_d;
        end
    end

    assign phase_o = phase_lut(idx_q);
    assign pos_o   = pos_q;

endmodule

// File: rtl/stepper_drive.sv
// Full-step stepper driver with a linear period ramp. Accelerates from
// DIV_MAX to DIV_MIN on start, decelerates back to DIV_MAX on stop and
// always comes to rest before taking a new direction.
//   CLK  : system clock
//   RSTn : async active-low reset
//   bus  : slave side of stepper_drive_if (dir/en in; step/phase/pos/busy out)
module stepper_drive
    import stepper_pkg::*;
#(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_MAX   = 8,
    parameter int unsigned DIV_MIN   = 4,
    parameter int unsigned RAMP_STEP = 2,
    parameter int unsigned POS_W     = 16,
    parameter bit          HOLD      = 1'b1
) (
    input  logic            CLK,
    input  logic            RSTn,
    stepper_drive_if.slave  bus
);

    localparam logic [DIV_W:0]   MaxW  = (DIV_W+1)'(DIV_MAX);
    localparam logic [DIV_W:0]   MinW  = (DIV_W+1)'(DIV_MIN);
    localparam logic [DIV_W:0]   RampW = (DIV_W+1)'(RAMP_STEP);
    localparam logic [DIV_W-1:0] PerMax = DIV_W'(DIV_MAX);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic             dir_l_q, dir_l_d;
    logic             step_q;
    logic             busy_q;
    logic             step_take;
    logic [DIV_W-1:0] period_new;
    logic [DIV_W:0]   per_ext, acc_ext, dec_ext;
    logic             hold_req;
    logic [3:0]       seq_phase;
    logic [POS_W-1:0] seq_pos;

    // Saturating ramp arithmetic, one bit wider than the period so the
    // intermediate sum/difference cannot wrap.
    always_comb begin
        per_ext = {1'b0, period_q};
        acc_ext = (per_ext < MinW + RampW) ? MinW : per_ext - RampW;
        dec_ext = (per_ext + RampW > MaxW) ? MaxW : per_ext + RampW;
    end

    // Keep moving in the latched direction.
    assign hold_req = bus.en && (bus.dir == dir_l_q);

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        timer_d    = timer_q;
        dir_l_d    = dir_l_q;
        step_take  = 1'b0;
        period_new = period_q;

        if (state_q == sIDLE) begin
            if (bus.en) begin
                dir_l_d  = bus.dir;
                period_d = PerMax;
                timer_d  = PerMax - DIV_W'(1);
                state_d  = sACCEL;
            end
        end else begin
            step_take = (timer_q == '0);

            // Period rule of the current state applies even if the state
            // changes on this same edge.
            unique case (state_q)
                sACCEL:  period_new = acc_ext[DIV_W-1:0];
                sDECEL:  period_new = dec_ext[DIV_W-1:0];
                default: period_new = period_q;
            endcase

            if (step_take) begin
                period_d = period_new;
                timer_d  = period_new - DIV_W'(1);
                if (state_q == sACCEL && period_new == MinW[DIV_W-1:0]) begin
                    state_d = sRUN;
                end
                if (state_q == sDECEL && period_new == PerMax) begin
                    state_d = sIDLE;
                end
            end else begin
                timer_d = timer_q - DIV_W'(1);
            end

            // A stop/resume request overrides the ramp-end transition.
            if (state_q != sDECEL && !hold_req) begin
                state_d = sDECEL;
            end else if (state_q == sDECEL && hold_req) begin
                state_d = sACCEL;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= sIDLE;
            period_q <= PerMax;
            timer_q  <= '0;
            dir_l_q  <= FW;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            dir_l_q  <= dir_l_d;
            step_q   <= step_take;
            busy_q   <= (state_d != sIDLE);
        end
    end

    stepper_phase_seq #(
        .POS_W (POS_W)
    ) u_phase_seq (
        .clk_i       (CLK),
        .rst_ni      (RSTn),
        .step_take_i (step_take),
        .dir_l_i     (dir_l_q),
        .phase_o     (seq_phase),
        .pos_o       (seq_pos)
    );

    assign bus.step  = step_q;
    assign bus.busy  = busy_q;
    assign bus.pos   = seq_pos;
    assign bus.phase = (HOLD || state_q != sIDLE) ? seq_phase : 4'b0000;

endmodule
